// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled 8N1 UART receiver feeding a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx_fifo #(
    parameter int unsigned DIV        = 27,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] d_out,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state;
    logic           rx_q1;
    logic           rx_s;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic           tick_clr;
    logic [3:0]     os_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           push_req;
`ifdef UART_RX_PARITY_EN
    logic           par_bit;
`endif

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nx;
    logic           do_push;
    logic           do_pop;

    assign tick     = (tick_cnt == TICK_LAST);
    assign tick_clr = (state == IDLE) && !rx_s;
    assign do_pop   = rd_en && (count != '0);
    assign do_push  = push_req && ((count != DEPTH_C) || do_pop);

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    // Oversample tick divider, re-phased on each detected start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_clr || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Receive FSM: mid-bit sampling, framing checks, push request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt == 4'd7) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            par_bit <= rx_s;
                            state   <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 4'd1;
                        if (os_cnt == 4'd15) begin
                            state     <= IDLE;
                            frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err <= ^{shreg, par_bit};
                            push_req   <= rx_s && !(^{shreg, par_bit});
`else
                            push_req  <= rx_s;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next occupancy after this edge's push/pop
    always_comb begin
        count_nx = count;
        if (do_push && !do_pop) begin
            count_nx = count + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_nx = count - (AW + 1)'(1);
        end
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers, read data and registered flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            d_out    <= 8'h00;
            rx_empty <= 1'b1;
            rx_full  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= push_req && (count == DEPTH_C) && !rd_en;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                d_out  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nx;
            rx_empty <= (count_nx == '0);
            rx_full  <= (count_nx == DEPTH_C);
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver, the receive-side counterpart of the transmit path. Deserialises an 8N1 serial stream on `rx` using 16x oversampling and mid-bit sampling. Received bytes are pushed into an internal FIFO, which a host drains with `rd_en`/`d_out`, using the same d/en/flag style as the transmit side. Frame errors and FIFO overruns are flagged with single-cycle pulses.

Parameters:
DIV, 27, clk cycles per oversample tick (tick rate = 16 x baud); legal range 1..65535.
FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset.
rx  input  1  serial line; idle high; asynchronous to clk.
rd_en  input  1  pop request; one byte per asserted cycle.
d_out  output  8  byte popped by the last accepted rd_en.
rx_empty  output  1  FIFO holds 0 bytes.
rx_full  output  1  FIFO holds FIFO_DEPTH bytes.
frame_err  output  1  1-cycle pulse: stop bit sampled 0.
overrun  output  1  1-cycle pulse: byte completed while FIFO full.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; tick counter, bit counter, FIFO pointers and count are cleared.
  - Synchroniser flops are set to 1.
  - Outputs: d_out=8'h00, rx_empty=1, rx_full=0, frame_err=0, overrun=0.
  - A frame in progress when reset asserts is discarded.
- Input conditioning: `rx` passes through a 2-flop synchroniser. All FSM decisions use the synchronised value `rx_s`.
- Tick generator:
  - Free-running counter 0..DIV-1; `tick` pulses for one clk when the count wraps.
  - Resets to 0 on every IDLE->START transition, so sampling phase is aligned to the start edge.
- FSM states:
  - IDLE: on `rx_s`=0, go to START and clear the tick count.
  - START: after 8 ticks (mid start bit), re-sample. If `rx_s`=1, treat as a glitch and return to IDLE with no flags. Otherwise go to DATA with bit count 0.
  - DATA: sample every 16 ticks and shift into the shift register LSB first. After the 8th bit, go to STOP (or PARITY when the optional feature is enabled).
  - STOP: after 16 ticks, sample. If `rx_s`=1, push the byte. If `rx_s`=0, pulse frame_err and discard the byte. Return to IDLE in either case.
  - A new start bit is only detected from IDLE. Back-to-back frames with a 1-bit stop are supported.
- Push/pop rules:
  - Push occurs in the clk after the stop sample.
  - Push when full (and no simultaneous rd_en): byte dropped, overrun pulses, FIFO contents unchanged.
  - rd_en with !rx_empty: d_out updates on the next posedge to the head entry, and the count decrements.
  - rd_en with rx_empty: ignored; d_out holds its value.
  - Push and pop in the same cycle when full: both complete, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: the pop is ignored and the push completes.
- Flags: rx_empty and rx_full are registered and reflect the count after the current edge. Pointers wrap modulo FIFO_DEPTH.
- Latency: the byte is visible (rx_empty=0) 1 clk after the mid-stop-bit sample, plus 2 clk of synchroniser delay measured from the line.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. A PARITY state after DATA samples the 9th bit 16 ticks later.
  - Adds output `parity_err` (1 bit, reset 0). It pulses 1 cycle, and the byte is discarded, when the XOR of the data bits and the parity bit is 1.
  - A frame with both a parity error and a stop error pulses both flags.
- Undefined: no PARITY state, no `parity_err` port, frames are 8N1.

Test Plan:
1. DIV=1; send 0xA5 (8N1, 16 clk/bit), then rd_en for 1 cycle -> rx_empty falls after the stop sample; next cycle d_out=0xA5, rx_empty=1.
2. DIV=1; drive rx low for 4 ticks, then high -> FSM returns to IDLE; rx_empty stays 1; no frame_err.
3. DIV=1; send 0x3C with stop bit 0 -> frame_err pulses exactly 1 cycle; rx_empty stays 1; then a valid 0x5A is received as 0x5A.
4. FIFO_DEPTH=16; send 0x00..0x10 (17 bytes) with no reads -> rx_full=1 after the 16th byte; overrun pulses on the 17th; draining gives 0x00..0x0F in order, then rx_empty=1.
5. Assert reset low mid-DATA of 0xFF, release, then send 0x81 -> only 0x81 is in the FIFO; all flags are 0 after reset.
6. UART_RX_PARITY_EN defined; send 0x07 with parity bit 0 -> parity_err pulses, byte dropped; send 0x07 with parity bit 1 -> d_out=0x07 after rd_en.
